// File: rtl/vga_hvsync_generator.sv
// 640x480@60 VGA raster timing: free-running beam counters plus sync and visible-area
// flags that always describe the hpos/vpos presented in the same cycle.
module vga_hvsync_generator #(
    parameter int H_DISPLAY    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter bit HSYNC_ACTIVE = 1'b0,
    parameter bit VSYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISIBLE    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VISIBLE    = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] hpos_next;
    logic [9:0] vpos_next;
    logic       hsync_next;
    logic       vsync_next;

    always_comb begin
        hpos_next = hpos + 10'd1;
        vpos_next = vpos;
        if (hpos == H_LAST) begin
            hpos_next = '0;
            vpos_next = (vpos == V_LAST) ? '0 : vpos + 10'd1;
        end

        // NOTE: syncs are decoded from the next-state counters so that, once registered,
        // they line up with the hpos/vpos registers instead of lagging them by one clock.
        hsync_next = ((hpos_next >= H_SYNC_START) && (hpos_next < H_SYNC_END))
                     ? HSYNC_ACTIVE : !HSYNC_ACTIVE;
        vsync_next = ((vpos_next >= V_SYNC_START) && (vpos_next < V_SYNC_END))
                     ? VSYNC_ACTIVE : !VSYNC_ACTIVE;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos  <= '0;
            vpos  <= '0;
            hsync <= !HSYNC_ACTIVE;
            vsync <= !VSYNC_ACTIVE;
        end else begin
            hpos  <= hpos_next;
            vpos  <= vpos_next;
            hsync <= hsync_next;
            vsync <= vsync_next;
        end
    end

    assign display_on = (hpos < H_VISIBLE) && (vpos < V_VISIBLE);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// Bench for vga_hvsync_generator: a default 640x480 instance plus a small-raster instance
// (active-high hsync) for frame-level behaviour, both checked against an arithmetic model.
module tb_vga_hvsync_generator;

    typedef struct {
        int hd, hf, hs, hb;
        int vd, vf, vs, vb;
        bit ha, va;
    } timing_t;

    typedef struct {
        int at;
        int h;
        int v;
        bit hs;
        bit vs;
        bit de;
    } vec_t;

    localparam int FRAME_B = 48 * 33;

    logic       clk = 1'b0;
    logic       reset_a = 1'b1;
    logic       reset_b = 1'b1;
    logic       a_hsync, a_vsync, a_display_on;
    logic [9:0] a_hpos, a_vpos;
    logic       b_hsync, b_vsync, b_display_on;
    logic [9:0] b_hpos, b_vpos;

    int checks = 0;
    int errors = 0;
    int na = 0;
    int nb = 0;
    timing_t tim_a, tim_b;

    always #5 clk = ~clk;

    vga_hvsync_generator dut_a (
        .clk(clk), .reset(reset_a), .hsync(a_hsync), .vsync(a_vsync),
        .display_on(a_display_on), .hpos(a_hpos), .vpos(a_vpos)
    );

    vga_hvsync_generator #(
        .H_DISPLAY(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(24), .V_FRONT(3), .V_SYNC(2), .V_BACK(4),
        .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset_b), .hsync(b_hsync), .vsync(b_vsync),
        .display_on(b_display_on), .hpos(b_hpos), .vpos(b_vpos)
    );

    function automatic logic [31:0] pack(input logic [9:0] h, input logic [9:0] v,
                                         input logic hs, input logic vs, input logic de);
        return {9'd0, h, v, hs, vs, de};
    endfunction

    // Beam state n clocks after the last reset edge, straight from the raster arithmetic.
    function automatic logic [31:0] model(input timing_t t, input int n);
        int ht, vt, h, v;
        bit hs, vs, de;
        ht = t.hd + t.hf + t.hs + t.hb;
        vt = t.vd + t.vf + t.vs + t.vb;
        h  = n % ht;
        v  = (n / ht) % vt;
        hs = (h >= t.hd + t.hf && h < t.hd + t.hf + t.hs) ? t.ha : !t.ha;
        vs = (v >= t.vd + t.vf && v < t.vd + t.vf + t.vs) ? t.va : !t.va;
        de = (h < t.hd) && (v < t.vd);
        return pack(10'(h), 10'(v), hs, vs, de);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_a(input string name);
        check(name, pack(a_hpos, a_vpos, a_hsync, a_vsync, a_display_on), model(tim_a, na));
    endtask

    task automatic check_b(input string name);
        check(name, pack(b_hpos, b_vpos, b_hsync, b_vsync, b_display_on), model(tim_b, nb));
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            na = reset_a ? 0 : na + 1;
            nb = reset_b ? 0 : nb + 1;
            #1;
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   low_cnt, de_cnt, vs_cnt, starts, last_start, vs_on, vs_off;
        logic prev_vs;

        tim_a = '{hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vf: 10, vs: 2, vb: 33,
                  ha: 1'b0, va: 1'b0};
        tim_b = '{hd: 32, hf: 4, hs: 8, hb: 4, vd: 24, vf: 3, vs: 2, vb: 4,
                  ha: 1'b1, va: 1'b0};

        // Checkpoints on the default raster, in clocks since reset release.
        vecs.push_back('{at: 1,    h: 1,   v: 0, hs: 1, vs: 1, de: 1});
        vecs.push_back('{at: 2,    h: 2,   v: 0, hs: 1, vs: 1, de: 1});
        vecs.push_back('{at: 3,    h: 3,   v: 0, hs: 1, vs: 1, de: 1});
        vecs.push_back('{at: 639,  h: 639, v: 0, hs: 1, vs: 1, de: 1});
        vecs.push_back('{at: 640,  h: 640, v: 0, hs: 1, vs: 1, de: 0});
        vecs.push_back('{at: 655,  h: 655, v: 0, hs: 1, vs: 1, de: 0});
        vecs.push_back('{at: 656,  h: 656, v: 0, hs: 0, vs: 1, de: 0});
        vecs.push_back('{at: 751,  h: 751, v: 0, hs: 0, vs: 1, de: 0});
        vecs.push_back('{at: 752,  h: 752, v: 0, hs: 1, vs: 1, de: 0});
        vecs.push_back('{at: 799,  h: 799, v: 0, hs: 1, vs: 1, de: 0});
        vecs.push_back('{at: 800,  h: 0,   v: 1, hs: 1, vs: 1, de: 1});
        vecs.push_back('{at: 1455, h: 655, v: 1, hs: 1, vs: 1, de: 0});
        vecs.push_back('{at: 1456, h: 656, v: 1, hs: 0, vs: 1, de: 0});
        vecs.push_back('{at: 1600, h: 0,   v: 2, hs: 1, vs: 1, de: 1});
        vecs.push_back('{at: 2400, h: 0,   v: 3, hs: 1, vs: 1, de: 1});

        // Reset held for three clocks.
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("reset_hold_a", pack(a_hpos, a_vpos, a_hsync, a_vsync, a_display_on),
                  pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1));
        end
        reset_a = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].at - na);
            check($sformatf("table[%0d]@%0d", i, vecs[i].at),
                  pack(a_hpos, a_vpos, a_hsync, a_vsync, a_display_on),
                  pack(10'(vecs[i].h), 10'(vecs[i].v), vecs[i].hs, vecs[i].vs, vecs[i].de));
        end

        // hsync active and visible clocks per line over three whole lines.
        for (int line = 0; line < 3; line++) begin
            low_cnt = 0;
            de_cnt  = 0;
            for (int i = 0; i < 800; i++) begin
                if (a_hsync === 1'b0) low_cnt++;
                if (a_display_on === 1'b1) de_cnt++;
                step(1);
            end
            check($sformatf("hsync_low_line%0d", line), low_cnt, 96);
            check($sformatf("display_line%0d", line), de_cnt, 640);
        end

        // Mid-frame reset on the default raster.
        step(6 * 800 + 300 - na);
        check("pre_reset_a", pack(a_hpos, a_vpos, a_hsync, a_vsync, a_display_on),
              pack(10'd300, 10'd6, 1'b1, 1'b1, 1'b1));
        reset_a = 1'b1;
        step(1);
        check("mid_reset_a", pack(a_hpos, a_vpos, a_hsync, a_vsync, a_display_on),
              pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1));
        reset_a = 1'b0;
        step(1);
        check("resume_a", pack(a_hpos, a_vpos, a_hsync, a_vsync, a_display_on),
              pack(10'd1, 10'd0, 1'b1, 1'b1, 1'b1));
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_a("resume_a_run");
        end

        // Small raster: three frames checked every clock, plus frame-level statistics.
        reset_b    = 1'b0;
        de_cnt     = b_display_on === 1'b1 ? 1 : 0;
        vs_cnt     = b_vsync === 1'b0 ? 1 : 0;
        prev_vs    = b_vsync;
        starts     = 0;
        last_start = 0;
        vs_on      = 0;
        vs_off     = 0;
        for (int c = 1; c <= 3 * FRAME_B + 50; c++) begin
            step(1);
            check_b("b_cycle");
            if (b_hpos === 10'd0 && b_vpos === 10'd0) begin
                starts++;
                check("frame_period", c - last_start, FRAME_B);
                check("frame_display", de_cnt, 32 * 24);
                check("frame_vsync", vs_cnt, 2 * 48);
                last_start = c;
                de_cnt     = 0;
                vs_cnt     = 0;
            end
            if (b_display_on === 1'b1) de_cnt++;
            if (b_vsync === 1'b0) vs_cnt++;
            if (prev_vs === 1'b1 && b_vsync === 1'b0) begin
                vs_on++;
                check("vsync_start_pos", pack(b_hpos, b_vpos, 1'b0, 1'b0, 1'b0),
                      pack(10'd0, 10'd27, 1'b0, 1'b0, 1'b0));
            end
            if (prev_vs === 1'b0 && b_vsync === 1'b1) begin
                vs_off++;
                check("vsync_end_pos", pack(b_hpos, b_vpos, 1'b0, 1'b0, 1'b0),
                      pack(10'd0, 10'd29, 1'b0, 1'b0, 1'b0));
            end
            prev_vs = b_vsync;
        end
        check("frame_starts", starts, 3);
        check("vsync_pulses", vs_on + vs_off, 6);

        // Simultaneous wrap of both counters.
        step((FRAME_B - 1 - nb % FRAME_B + FRAME_B) % FRAME_B);
        check("last_pixel_b", pack(b_hpos, b_vpos, b_hsync, b_vsync, b_display_on),
              pack(10'd47, 10'd32, 1'b0, 1'b1, 1'b0));
        step(1);
        check("frame_wrap_b", pack(b_hpos, b_vpos, b_hsync, b_vsync, b_display_on),
              pack(10'd0, 10'd0, 1'b0, 1'b1, 1'b1));

        // Mid-frame reset on the small raster.
        step((15 * 48 + 20 - nb % FRAME_B + FRAME_B) % FRAME_B);
        check("pre_reset_b", pack(b_hpos, b_vpos, b_hsync, b_vsync, b_display_on),
              pack(10'd20, 10'd15, 1'b0, 1'b1, 1'b1));
        reset_b = 1'b1;
        step(1);
        check("mid_reset_b", pack(b_hpos, b_vpos, b_hsync, b_vsync, b_display_on),
              pack(10'd0, 10'd0, 1'b0, 1'b1, 1'b1));
        reset_b = 1'b0;
        step(1);
        check("resume_b", pack(b_hpos, b_vpos, b_hsync, b_vsync, b_display_on),
              pack(10'd1, 10'd0, 1'b0, 1'b1, 1'b1));

        // Random run lengths and random reset pulses on both instances.
        for (int iter = 0; iter < 40; iter++) begin
            int len;
            len = $urandom_range(1, 500);
            for (int i = 0; i < len; i++) begin
                step(1);
                check_a("rand_a");
                check_b("rand_b");
            end
            reset_a = ($urandom_range(0, 2) == 0);
            reset_b = ($urandom_range(0, 2) == 0);
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) begin
                step(1);
                check_a("rand_reset_a");
                check_b("rand_reset_b");
            end
            reset_a = 1'b0;
            reset_b = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
